// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Shares one add/subtract unit between two requesters, r0 and r1. A command
//   is accepted over a valid/ready handshake. Its operands are registered onto
//   au_*. The block waits LATENCY cycles, captures the unit's result, and
//   returns it over a response handshake. Only one operation is in flight at a
//   time. When both requesters ask at once, the grants alternate through a
//   priority pointer that moves to the other requester after each response.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   rN_valid / rN_ready            command handshake (ready is combinational)
//   rN_a, rN_b, rN_sel             operands; sel 0 = add, 1 = subtract
//   rN_rsp_valid / rN_rsp_ready    response handshake
//   rN_sum, rN_carry, rN_overflow  registered result returned to requester N
//   au_a, au_b, au_sel             registered operands to the shared unit
//   au_sum, au_carry, au_overflow  result from the shared unit
module addsub_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_sel,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_sum,
  output logic             r0_carry,
  output logic             r0_overflow,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_sel,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_sum,
  output logic             r1_carry,
  output logic             r1_overflow,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic             au_sel,
  input  logic [WIDTH-1:0] au_sum,
  input  logic             au_carry,
  input  logic             au_overflow
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("addsub_arbiter: LATENCY must be in 1..15");
  end

  state_t     state;
  logic       prio;   // requester that wins when both are valid
  logic       owner;  // requester whose operation is in flight
  logic [3:0] count;
  logic       grant0;
  logic       grant1;

  // The pointer only breaks ties. A lone requester always wins.
  always_comb begin
    grant0 = r0_valid & (~r1_valid | ~prio);
    grant1 = r1_valid & (~r0_valid | prio);
  end

  assign r0_ready = (state == IDLE) & grant0;
  assign r1_ready = (state == IDLE) & grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prio         <= 1'b0;
      owner        <= 1'b0;
      count        <= 4'd0;
      au_a         <= '0;
      au_b         <= '0;
      au_sel       <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r0_sum       <= '0;
      r0_carry     <= 1'b0;
      r0_overflow  <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_sum       <= '0;
      r1_carry     <= 1'b0;
      r1_overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A grant in IDLE is a handshake, because ready equals the grant here.
          if (grant0 | grant1) begin
            owner  <= grant1;
            au_a   <= grant1 ? r1_a : r0_a;
            au_b   <= grant1 ? r1_b : r0_b;
            au_sel <= grant1 ? r1_sel : r0_sel;
            count  <= LAT;
            state  <= EXEC;
          end
        end
        EXEC: begin
          count <= count - 4'd1;
          // The unit has had LATENCY full cycles since the operands were driven.
          if (count == 4'd1) begin
            if (owner) begin
              r1_rsp_valid <= 1'b1;
              r1_sum       <= au_sum;
              r1_carry     <= au_carry;
              r1_overflow  <= au_overflow;
            end else begin
              r0_rsp_valid <= 1'b1;
              r0_sum       <= au_sum;
              r0_carry     <= au_carry;
              r0_overflow  <= au_overflow;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (owner ? r1_rsp_ready : r0_rsp_ready) begin
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            prio         <= ~owner;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // dut1: LATENCY = 1
  logic         r0_valid, r0_ready, r0_sel, r0_rsp_valid, r0_rsp_ready, r0_carry, r0_overflow;
  logic         r1_valid, r1_ready, r1_sel, r1_rsp_valid, r1_rsp_ready, r1_carry, r1_overflow;
  logic [W-1:0] r0_a, r0_b, r0_sum, r1_a, r1_b, r1_sum;
  logic [W-1:0] au_a, au_b, au_sum;
  logic         au_sel, au_carry, au_overflow;

  // dut3: LATENCY = 3; only its r0 side is exercised
  logic         q0_valid, q0_ready, q0_sel, q0_rsp_valid, q0_rsp_ready, q0_carry, q0_overflow;
  logic         q1_valid, q1_ready, q1_sel, q1_rsp_valid, q1_rsp_ready, q1_carry, q1_overflow;
  logic [W-1:0] q0_a, q0_b, q0_sum, q1_a, q1_b, q1_sum;
  logic [W-1:0] qu_a, qu_b, qu_sum;
  logic         qu_sel, qu_carry, qu_overflow;

  // Stand-in for the shared arithmetic unit: {overflow, carry/borrow, sum}
  function automatic logic [W+1:0] unit_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sel);
    logic [W:0] r;
    logic       ovf;
    if (!sel) begin
      r   = {1'b0, a} + {1'b0, b};
      ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r   = {1'b0, a} - {1'b0, b};
      ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {ovf, r};
  endfunction

  assign {au_overflow, au_carry, au_sum} = unit_model(au_a, au_b, au_sel);
  assign {qu_overflow, qu_carry, qu_sum} = unit_model(qu_a, qu_b, qu_sel);

  addsub_arbiter #(.WIDTH(W), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready), .r0_sum(r0_sum),
    .r0_carry(r0_carry), .r0_overflow(r0_overflow),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready), .r1_sum(r1_sum),
    .r1_carry(r1_carry), .r1_overflow(r1_overflow),
    .au_a(au_a), .au_b(au_b), .au_sel(au_sel),
    .au_sum(au_sum), .au_carry(au_carry), .au_overflow(au_overflow)
  );

  addsub_arbiter #(.WIDTH(W), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .r0_valid(q0_valid), .r0_ready(q0_ready), .r0_a(q0_a), .r0_b(q0_b), .r0_sel(q0_sel),
    .r0_rsp_valid(q0_rsp_valid), .r0_rsp_ready(q0_rsp_ready), .r0_sum(q0_sum),
    .r0_carry(q0_carry), .r0_overflow(q0_overflow),
    .r1_valid(q1_valid), .r1_ready(q1_ready), .r1_a(q1_a), .r1_b(q1_b), .r1_sel(q1_sel),
    .r1_rsp_valid(q1_rsp_valid), .r1_rsp_ready(q1_rsp_ready), .r1_sum(q1_sum),
    .r1_carry(q1_carry), .r1_overflow(q1_overflow),
    .au_a(qu_a), .au_b(qu_b), .au_sel(qu_sel),
    .au_sum(qu_sum), .au_carry(qu_carry), .au_overflow(qu_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_sel = 0; r0_rsp_ready = 1;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_sel = 0; r1_rsp_ready = 1;
    q0_valid = 0; q0_a = 0; q0_b = 0; q0_sel = 0; q0_rsp_ready = 1;
    q1_valid = 0; q1_a = 0; q1_b = 0; q1_sel = 0; q1_rsp_ready = 1;

    // Reset state
    #2;
    check("rst_au_a", 32'(au_a), 0);
    check("rst_r0_rsp_valid", 32'(r0_rsp_valid), 0);
    check("rst_r1_sum", 32'(r1_sum), 0);
    tick(); tick();
    rst = 0;

    // Add with overflow: r0 issues 0x7FFF + 0x0001
    r0_valid = 1; r0_a = 16'h7FFF; r0_b = 16'h0001; r0_sel = 0;
    #1;
    check("add_r0_ready", 32'(r0_ready), 1);
    check("add_r1_ready", 32'(r1_ready), 0);
    tick();                                    // accept edge
    r0_valid = 0;
    check("add_exec_ready", 32'(r0_ready), 0);
    check("add_au_a", 32'(au_a), 32'h7FFF);
    check("add_rsp_early", 32'(r0_rsp_valid), 0);
    tick();                                    // capture edge (LATENCY = 1)
    check("add_rsp_valid", 32'(r0_rsp_valid), 1);
    check("add_sum", 32'(r0_sum), 32'h8000);
    check("add_carry", 32'(r0_carry), 0);
    check("add_overflow", 32'(r0_overflow), 1);
    check("add_r1_rsp_valid", 32'(r1_rsp_valid), 0);
    tick();                                    // response handshake
    check("add_rsp_clear", 32'(r0_rsp_valid), 0);

    // Subtract with borrow: r1 issues 0x0000 - 0x0001
    r1_valid = 1; r1_a = 16'h0000; r1_b = 16'h0001; r1_sel = 1;
    #1;
    check("sub_r1_ready", 32'(r1_ready), 1);
    tick();
    r1_valid = 0;
    check("sub_au_sel", 32'(au_sel), 1);
    tick();
    check("sub_rsp_valid", 32'(r1_rsp_valid), 1);
    check("sub_sum", 32'(r1_sum), 32'hFFFF);
    check("sub_carry", 32'(r1_carry), 1);
    check("sub_overflow", 32'(r1_overflow), 0);
    check("sub_r0_rsp_valid", 32'(r0_rsp_valid), 0);
    check("sub_r0_sum_kept", 32'(r0_sum), 32'h8000);
    tick();

    // Contention: both valid continuously; r0 = 1 + 2 = 3, r1 = 5 - 3 = 2
    r0_valid = 1; r0_a = 16'd1; r0_b = 16'd2; r0_sel = 0;
    r1_valid = 1; r1_a = 16'd5; r1_b = 16'd3; r1_sel = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fair%0d_r0_ready", i), 32'(r0_ready), 32'((i % 2) == 0));
      check($sformatf("fair%0d_r1_ready", i), 32'(r1_ready), 32'((i % 2) == 1));
      tick();
      check($sformatf("fair%0d_ready_pulse", i), 32'({r0_ready, r1_ready}), 0);
      tick();
      check($sformatf("fair%0d_resp_ready", i), 32'({r0_ready, r1_ready}), 0);
      check($sformatf("fair%0d_rsp_valids", i), 32'({r1_rsp_valid, r0_rsp_valid}),
            ((i % 2) == 0) ? 32'b01 : 32'b10);
      if ((i % 2) == 0) check($sformatf("fair%0d_r0_sum", i), 32'(r0_sum), 3);
      else              check($sformatf("fair%0d_r1_sum", i), 32'(r1_sum), 2);
      tick();
    end

    // Backpressure: r0 holds rsp_ready low for 5 cycles
    r0_rsp_ready = 0;
    #1;
    check("bp_r0_ready", 32'(r0_ready), 1);
    tick();
    tick();
    check("bp_rsp_valid", 32'(r0_rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp%0d_rsp_valid", k), 32'(r0_rsp_valid), 1);
      check($sformatf("bp%0d_sum", k), 32'({r0_carry, r0_overflow, r0_sum}), 32'h0_0003);
      check($sformatf("bp%0d_r1_ready", k), 32'(r1_ready), 0);
    end
    r0_rsp_ready = 1;
    tick();                                    // r0 response handshake
    check("bp_rsp_clear", 32'(r0_rsp_valid), 0);
    check("bp_r1_granted", 32'(r1_ready), 1);
    check("bp_r0_not_granted", 32'(r0_ready), 0);
    tick();
    r0_valid = 0; r1_valid = 0;
    tick();
    check("bp_r1_rsp", 32'({r1_rsp_valid, r1_sum}), 32'h1_0002);
    tick();

    // LATENCY = 3 timing on dut3: 0x1234 + 0x0FFF = 0x2233
    q0_valid = 1; q0_a = 16'h1234; q0_b = 16'h0FFF; q0_sel = 0;
    #1;
    check("lat3_ready", 32'(q0_ready), 1);
    tick();
    q0_valid = 0;
    for (int k = 1; k < 3; k++) begin
      tick();
      check($sformatf("lat3_c%0d_rsp_valid", k), 32'(q0_rsp_valid), 0);
      check($sformatf("lat3_c%0d_au", k), 32'({qu_a, qu_b}), 32'h1234_0FFF);
    end
    tick();
    check("lat3_rsp_valid", 32'(q0_rsp_valid), 1);
    check("lat3_sum", 32'(q0_sum), 32'h2233);
    check("lat3_au_hold", 32'({qu_a, qu_b}), 32'h1234_0FFF);
    tick();
    check("lat3_rsp_clear", 32'(q0_rsp_valid), 0);

    // Complete one r0 op so the pointer favours r1 before the reset test
    r0_valid = 1; r0_a = 16'h0010; r0_b = 16'h0020; r0_sel = 0;
    tick();
    r0_valid = 0;
    tick();
    check("pre_rst_sum", 32'(r0_sum), 32'h0030);
    tick();

    // Reset mid-EXEC
    r0_valid = 1; r0_a = 16'h00FF; r0_b = 16'h0001; r0_sel = 0;
    tick();                                    // accept
    r0_valid = 0;
    #2;
    rst = 1;
    #1;
    check("mid_rst_au_a", 32'(au_a), 0);
    check("mid_rst_r0_sum", 32'(r0_sum), 0);
    check("mid_rst_rsp_valid", 32'(r0_rsp_valid), 0);
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst%0d_no_rsp", k), 32'({r0_rsp_valid, r1_rsp_valid}), 0);
    end
    r0_valid = 1; r1_valid = 1;
    #1;
    check("post_rst_r0_granted", 32'(r0_ready), 1);
    check("post_rst_r1_not_granted", 32'(r1_ready), 0);
    r0_valid = 0; r1_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Arbitrates and sequences one shared 16-bit adder-subtractor between two requesters (r0, r1).
- Accepts an operand pair plus an operation select from either requester over a valid/ready handshake.
- Drives registered operands to the shared unit and waits a programmable number of cycles.
- Captures Sum/Carry/Overflow and returns them to the issuing requester over a response handshake.
- Sits between ALU-level control logic and the single arithmetic unit; one operation is in flight at a time.

Parameters:
WIDTH, 16, operand/result width
LATENCY, 1, cycles the shared unit needs after operands are driven (legal range 1-15)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
r0_valid  input  1  requester 0 command valid
r0_ready  output  1  requester 0 command accepted
r0_a, r0_b  input  WIDTH  requester 0 operands (augend/minuend, addend/subtrahend)
r0_sel  input  1  0 = add, 1 = subtract
r0_rsp_valid  output  1  requester 0 response valid
r0_rsp_ready  input  1  requester 0 response consumed
r0_sum  output  WIDTH  result to requester 0
r0_carry, r0_overflow  output  1  status to requester 0
r1_*  (same set as r0_*, for requester 1)
au_a, au_b  output  WIDTH  operands to shared unit
au_sel  output  1  operation to shared unit
au_sum  input  WIDTH  shared unit result
au_carry, au_overflow  input  1  shared unit status (carry = bit WIDTH of the WIDTH+1 result; borrow on subtract)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs and registers 0; FSM = IDLE; priority pointer = 0; counter = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant rule:
  - Exactly one rX_valid high: that requester is granted.
  - Both high: requester named by the priority pointer is granted.
- IDLE, ready: rX_ready is combinational, high only for the granted requester and only in IDLE.
- IDLE, accept (valid & ready at edge T):
  - Register au_a/au_b/au_sel from the winner; record owner.
  - Load counter = LATENCY; go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - At the edge where counter == 1, capture au_sum/au_carry/au_overflow into the owner's response registers, assert owner's rsp_valid, go to RESP.
  - au_* held stable throughout.
- Latency: rsp_valid first high in cycle T+LATENCY+1.
- RESP:
  - Owner's rsp_valid and result held until rsp_ready sampled high.
  - On that edge: rsp_valid clears, priority pointer = other requester, go to IDLE.
  - No command is accepted in RESP or EXEC; both rX_ready are low.
- Throughput: with rsp_ready tied high, one op per LATENCY+2 cycles.
- Non-owner outputs: the non-owner's rsp_valid stays 0; its response registers keep their last values.
- After completion: au_* keep their last values (no toggling) until the next accept.
- Widths: no arithmetic is performed in this block; results pass through unmodified at WIDTH bits.
- Requester protocol: a requester holds valid/a/b/sel stable until ready is seen; changing operands while valid and not ready is a protocol violation.
- Reset mid-operation (EXEC or RESP): in-flight op is dropped, no response is produced, state returns to reset values.
- Invalid LATENCY values are out of scope; simulation asserts LATENCY in 1..15.

Test Plan:
- Add overflow (LATENCY=1): r0 issues a=0x7FFF, b=0x0001, sel=0 at edge T -> r0_rsp_valid in cycle T+2 with sum=0x8000, carry=0, overflow=1; r1_rsp_valid stays 0.
- Subtract borrow: r1 issues a=0x0000, b=0x0001, sel=1 -> r1_sum=0xFFFF, carry=1, overflow=0; au_sel=1 during EXEC.
- Contention and fairness: r0 and r1 both valid continuously after reset -> grants alternate r0, r1, r0, r1; each ready is a single-cycle pulse; exactly one response per grant to the correct requester.
- Backpressure: r0 rsp_ready low for 5 cycles after rsp_valid -> sum/status stable, r1_ready stays 0 throughout, and r1 is granted the cycle after the r0 response handshake.
- LATENCY=3 timing: accept at edge T -> rsp_valid first high in cycle T+4; au_a/au_b unchanged across all EXEC cycles.
- Reset mid-EXEC: assert rst one cycle after accept -> all outputs 0 immediately (asynchronous), no rsp_valid ever appears for the dropped op, and the next request after reset is granted to r0 if both are valid.
